// File: rtl/ddr_cmd_encoder.sv
// ddr_cmd_encoder
// Turns the init sequencer's one-hot command strobes into registered DDR4
// command/address pins, keeps shadow copies of MR0..MR6, publishes the decoded
// latency fields and flags MRS/ZQCL spacing, strobe conflicts and incomplete
// configuration.
//
// Ports:
//   CK_t, reset                  clock, synchronous active-high reset
//   mrs_rdy, zqcl_rdy, des_rdy   command strobes (MRS has priority over ZQCL)
//   ini_done                     init sequencer finished
//   mode_reg[21:0]               [20:18] MR select {BG0,BA1,BA0}, [17:0] A17..A0
//   CS_n..WE_n, BG, BA, A        registered DDR4 command/address pins
//   mr_valid[6:0]                MRn written since reset
//   cl/bl/al/cwl/tccdl_code,
//   rd_pre, wr_pre               fields decoded from the shadow registers
//   cfg_ready                    encoder in READY
//   *_err                        single-cycle error pulses aligned with the pins
module ddr_cmd_encoder #(
  parameter int unsigned TMRD = 8,
  parameter int unsigned TMOD = 24
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        mrs_rdy,
  input  logic        zqcl_rdy,
  input  logic        des_rdy,
  input  logic        ini_done,
  input  logic [21:0] mode_reg,
  output logic        CS_n,
  output logic        ACT_n,
  output logic        RAS_n,
  output logic        CAS_n,
  output logic        WE_n,
  output logic [1:0]  BG,
  output logic [1:0]  BA,
  output logic [17:0] A,
  output logic [6:0]  mr_valid,
  output logic [3:0]  cl_code,
  output logic [1:0]  bl_code,
  output logic [1:0]  al_code,
  output logic [2:0]  cwl_code,
  output logic [2:0]  tccdl_code,
  output logic        rd_pre,
  output logic        wr_pre,
  output logic        cfg_ready,
  output logic        mrs_gap_err,
  output logic        zq_gap_err,
  output logic        conflict_err,
  output logic        cfg_err
);

  typedef enum logic {
    ST_CONFIG,
    ST_READY
  } state_e;

  localparam logic [5:0] MRS_GAP_MIN = 6'(TMRD - 1);
  localparam logic [5:0] ZQ_GAP_MIN  = 6'(TMOD - 1);
  localparam logic [5:0] SINCE_MAX   = 6'd63;

  // command pin order: {CS_n, ACT_n, RAS_n, CAS_n, WE_n}
  localparam logic [4:0] CMD_DES  = 5'b11111;
  localparam logic [4:0] CMD_MRS  = 5'b01000;
  localparam logic [4:0] CMD_ZQCL = 5'b01110;

  state_e      state_q, state_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  ba_q, ba_d;
  logic [17:0] a_q, a_d;
  logic [17:0] shadow_q [7];
  logic [17:0] shadow_d [7];
  logic [6:0]  mr_valid_q, mr_valid_d;
  logic [5:0]  since_mrs_q, since_mrs_d;
  logic        mrs_gap_err_q, mrs_gap_err_d;
  logic        zq_gap_err_q, zq_gap_err_d;
  logic        conflict_err_q, conflict_err_d;
  logic        cfg_err_q, cfg_err_d;

  logic        mrs_acc;
  logic        zq_acc;
  logic        unused_ok;

  always_comb begin
    mrs_acc = mrs_rdy;
    // a simultaneous MRS wins, so ZQCL is only accepted on its own
    zq_acc  = zqcl_rdy & ~mrs_rdy;

    cmd_d = CMD_DES;
    bg_d  = '0;
    ba_d  = '0;
    a_d   = '0;
    if (mrs_acc) begin
      cmd_d = CMD_MRS;
      bg_d  = {1'b0, mode_reg[20]};
      ba_d  = mode_reg[19:18];
      a_d   = mode_reg[17:0];
    end else if (zq_acc) begin
      cmd_d    = CMD_ZQCL;
      a_d[10]  = 1'b1;
    end

    if (mrs_acc) begin
      since_mrs_d = '0;
    end else if (since_mrs_q == SINCE_MAX) begin
      since_mrs_d = SINCE_MAX;
    end else begin
      since_mrs_d = since_mrs_q + 6'd1;
    end

    // select 7 (RCW) matches no shadow slot, so it only reaches the pins
    mr_valid_d = mr_valid_q;
    for (int unsigned i = 0; i < 7; i++) begin
      shadow_d[i] = shadow_q[i];
      if (mrs_acc && (mode_reg[20:18] == 3'(i))) begin
        shadow_d[i]   = mode_reg[17:0];
        mr_valid_d[i] = 1'b1;
      end
    end

    mrs_gap_err_d  = mrs_acc && (since_mrs_q < MRS_GAP_MIN);
    zq_gap_err_d   = zq_acc && (since_mrs_q < ZQ_GAP_MIN);
    conflict_err_d = mrs_rdy & zqcl_rdy;

    state_d   = state_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_CONFIG: begin
        if (ini_done) begin
          if (mr_valid_q == 7'h7F) begin
            state_d = ST_READY;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CONFIG;
    endcase
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_q        <= ST_CONFIG;
      cmd_q          <= CMD_DES;
      bg_q           <= '0;
      ba_q           <= '0;
      a_q            <= '0;
      mr_valid_q     <= '0;
      since_mrs_q    <= SINCE_MAX;
      mrs_gap_err_q  <= 1'b0;
      zq_gap_err_q   <= 1'b0;
      conflict_err_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      for (int unsigned i = 0; i < 7; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      bg_q           <= bg_d;
      ba_q           <= ba_d;
      a_q            <= a_d;
      mr_valid_q     <= mr_valid_d;
      since_mrs_q    <= since_mrs_d;
      mrs_gap_err_q  <= mrs_gap_err_d;
      zq_gap_err_q   <= zq_gap_err_d;
      conflict_err_q <= conflict_err_d;
      cfg_err_q      <= cfg_err_d;
      for (int unsigned i = 0; i < 7; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign {CS_n, ACT_n, RAS_n, CAS_n, WE_n} = cmd_q;
  assign BG = bg_q;
  assign BA = ba_q;
  assign A  = a_q;

  assign mr_valid   = mr_valid_q;
  assign cl_code    = {shadow_q[0][6], shadow_q[0][5], shadow_q[0][4], shadow_q[0][2]};
  assign bl_code    = shadow_q[0][1:0];
  assign al_code    = shadow_q[1][4:3];
  assign cwl_code   = shadow_q[2][5:3];
  assign tccdl_code = shadow_q[6][12:10];
  assign rd_pre     = shadow_q[4][11];
  assign wr_pre     = shadow_q[4][12];
  assign cfg_ready  = (state_q == ST_READY);

  assign mrs_gap_err  = mrs_gap_err_q;
  assign zq_gap_err   = zq_gap_err_q;
  assign conflict_err = conflict_err_q;
  assign cfg_err      = cfg_err_q;

  // des_rdy selects the same DES encoding as no strobe; mode_reg[21] is reserved
  assign unused_ok = ^{des_rdy, mode_reg[21], shadow_q[0], shadow_q[1], shadow_q[2],
                       shadow_q[3], shadow_q[4], shadow_q[5], shadow_q[6]};

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// Directed bench for ddr_cmd_encoder: each task drives one scenario and checks
// the registered pins, decoded fields and error pulses against hand values.
module tb_ddr_cmd_encoder;

  logic        CK_t = 1'b0;
  logic        reset;
  logic        mrs_rdy, zqcl_rdy, des_rdy, ini_done;
  logic [21:0] mode_reg;
  logic        CS_n, ACT_n, RAS_n, CAS_n, WE_n;
  logic [1:0]  BG, BA;
  logic [17:0] A;
  logic [6:0]  mr_valid;
  logic [3:0]  cl_code;
  logic [1:0]  bl_code, al_code;
  logic [2:0]  cwl_code, tccdl_code;
  logic        rd_pre, wr_pre, cfg_ready;
  logic        mrs_gap_err, zq_gap_err, conflict_err, cfg_err;

  int checks = 0;
  int passed = 0;

  // {CS_n, ACT_n, RAS_n, CAS_n, WE_n}
  localparam logic [4:0] P_DES  = 5'b11111;
  localparam logic [4:0] P_MRS  = 5'b01000;
  localparam logic [4:0] P_ZQCL = 5'b01110;

  logic [4:0] pins;
  logic [3:0] errs;  // {mrs_gap, zq_gap, conflict, cfg}
  assign pins = {CS_n, ACT_n, RAS_n, CAS_n, WE_n};
  assign errs = {mrs_gap_err, zq_gap_err, conflict_err, cfg_err};

  ddr_cmd_encoder #(.TMRD(8), .TMOD(24)) dut (
    .CK_t(CK_t), .reset(reset), .mrs_rdy(mrs_rdy), .zqcl_rdy(zqcl_rdy),
    .des_rdy(des_rdy), .ini_done(ini_done), .mode_reg(mode_reg),
    .CS_n(CS_n), .ACT_n(ACT_n), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
    .BG(BG), .BA(BA), .A(A), .mr_valid(mr_valid), .cl_code(cl_code),
    .bl_code(bl_code), .al_code(al_code), .cwl_code(cwl_code),
    .tccdl_code(tccdl_code), .rd_pre(rd_pre), .wr_pre(wr_pre),
    .cfg_ready(cfg_ready), .mrs_gap_err(mrs_gap_err), .zq_gap_err(zq_gap_err),
    .conflict_err(conflict_err), .cfg_err(cfg_err)
  );

  always #5 CK_t = ~CK_t;

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue_mrs(input logic [2:0] sel, input logic [17:0] val);
    mode_reg = {1'b0, sel, val};
    mrs_rdy  = 1'b1;
    tick();
    mrs_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // strobes active during reset must be ignored
    reset = 1'b1; mrs_rdy = 1'b1; zqcl_rdy = 1'b1; ini_done = 1'b1;
    mode_reg = {1'b0, 3'b000, 18'h3FFFF};
    tick(); tick();
    mrs_rdy = 1'b0; zqcl_rdy = 1'b0; ini_done = 1'b0; reset = 1'b0;
    checks++; if (pins !== P_DES) $display("FAIL reset_pins got %b exp %b", pins, P_DES); else passed++;
    checks++; if ({BG, BA, A} !== 22'h0) $display("FAIL reset_addr got %h exp 0", {BG, BA, A}); else passed++;
    checks++; if (mr_valid !== 7'h00) $display("FAIL reset_mr_valid got %h exp 00", mr_valid); else passed++;
    checks++; if ({cl_code, bl_code, al_code, cwl_code, tccdl_code, rd_pre, wr_pre} !== 16'h0)
      $display("FAIL reset_fields got %h exp 0", {cl_code, bl_code, al_code, cwl_code, tccdl_code, rd_pre, wr_pre}); else passed++;
    checks++; if ({cfg_ready, errs} !== 5'b0) $display("FAIL reset_status got %b exp 00000", {cfg_ready, errs}); else passed++;
  endtask

  task automatic test_first_mrs();
    issue_mrs(3'b000, 18'h00054);
    checks++; if (pins !== P_MRS) $display("FAIL first_mrs_pins got %b exp %b", pins, P_MRS); else passed++;
    checks++; if ({BG, BA, A} !== {2'b00, 2'b00, 18'h00054}) $display("FAIL first_mrs_addr got %h exp 00054", {BG, BA, A}); else passed++;
    // 0x54: A6=1 A5=0 A4=1 A2=1
    checks++; if (cl_code !== 4'b1011) $display("FAIL first_mrs_cl got %b exp 1011", cl_code); else passed++;
    checks++; if (bl_code !== 2'b00) $display("FAIL first_mrs_bl got %b exp 00", bl_code); else passed++;
    checks++; if (mr_valid !== 7'h01) $display("FAIL first_mrs_mr_valid got %h exp 01", mr_valid); else passed++;
    checks++; if (errs !== 4'b0) $display("FAIL first_mrs_errs got %b exp 0000", errs); else passed++;
    tick();
    checks++; if (pins !== P_DES) $display("FAIL first_mrs_des got %b exp %b", pins, P_DES); else passed++;
  endtask

  task automatic test_init_sequence();
    logic [2:0]  sels [7];
    logic [17:0] vals [7];
    sels = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
    vals = '{18'h00003, 18'h01400, 18'h00021, 18'h00800, 18'h00018, 18'h00010, 18'h00056};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i != 0) idle(7);
      issue_mrs(sels[i], vals[i]);
      checks++; if ({pins, BG, BA, A} !== {P_MRS, 1'b0, sels[i], vals[i]})
        $display("FAIL init_mrs%0d_bus got %h exp %h", sels[i], {pins, BG, BA, A}, {P_MRS, 1'b0, sels[i], vals[i]}); else passed++;
      checks++; if (errs !== 4'b0) $display("FAIL init_mrs%0d_errs got %b exp 0000", sels[i], errs); else passed++;
    end
    idle(23);
    zqcl_rdy = 1'b1; tick(); zqcl_rdy = 1'b0;
    checks++; if ({pins, BG, BA, A} !== {P_ZQCL, 4'b0, 18'h00400})
      $display("FAIL init_zqcl_bus got %h exp %h", {pins, BG, BA, A}, {P_ZQCL, 4'b0, 18'h00400}); else passed++;
    checks++; if (errs !== 4'b0) $display("FAIL init_zqcl_errs got %b exp 0000", errs); else passed++;
    checks++; if (mr_valid !== 7'h7F) $display("FAIL init_mr_valid got %h exp 7f", mr_valid); else passed++;
    checks++; if ({cl_code, bl_code, al_code, cwl_code, tccdl_code, rd_pre, wr_pre} !== {4'b1011, 2'b10, 2'b10, 3'b011, 3'b101, 1'b1, 1'b0})
      $display("FAIL init_fields got %h exp %h", {cl_code, bl_code, al_code, cwl_code, tccdl_code, rd_pre, wr_pre},
               {4'b1011, 2'b10, 2'b10, 3'b011, 3'b101, 1'b1, 1'b0}); else passed++;
    checks++; if (cfg_ready !== 1'b0) $display("FAIL init_pre_ready got %b exp 0", cfg_ready); else passed++;
    ini_done = 1'b1; tick(); ini_done = 1'b0;
    checks++; if ({cfg_ready, cfg_err} !== 2'b10) $display("FAIL init_ready got %b exp 10", {cfg_ready, cfg_err}); else passed++;
    // MRS still accepted in READY
    idle(8);
    issue_mrs(3'b010, 18'h00028);
    checks++; if ({pins, cwl_code, cfg_ready} !== {P_MRS, 3'b101, 1'b1})
      $display("FAIL ready_mrs got %b exp %b", {pins, cwl_code, cfg_ready}, {P_MRS, 3'b101, 1'b1}); else passed++;
  endtask

  task automatic test_gap_errors();
    do_reset();
    issue_mrs(3'b000, 18'h00001);
    idle(2);
    issue_mrs(3'b001, 18'h00008);
    checks++; if ({pins, A} !== {P_MRS, 18'h00008}) $display("FAIL gap_mrs_bus got %h exp %h", {pins, A}, {P_MRS, 18'h00008}); else passed++;
    checks++; if (errs !== 4'b1000) $display("FAIL gap_mrs_err got %b exp 1000", errs); else passed++;
    tick();
    checks++; if (errs !== 4'b0000) $display("FAIL gap_mrs_pulse got %b exp 0000", errs); else passed++;
    idle(8);
    zqcl_rdy = 1'b1; tick(); zqcl_rdy = 1'b0;
    checks++; if (pins !== P_ZQCL) $display("FAIL gap_zq_pins got %b exp %b", pins, P_ZQCL); else passed++;
    checks++; if (errs !== 4'b0100) $display("FAIL gap_zq_err got %b exp 0100", errs); else passed++;
    tick();
    checks++; if (errs !== 4'b0000) $display("FAIL gap_zq_pulse got %b exp 0000", errs); else passed++;
    // boundary: seven cycles apart still flags, eight does not
    issue_mrs(3'b000, 18'h00002);
    idle(6);
    issue_mrs(3'b000, 18'h00003);
    checks++; if (mrs_gap_err !== 1'b1) $display("FAIL gap_7_err got %b exp 1", mrs_gap_err); else passed++;
    idle(7);
    issue_mrs(3'b000, 18'h00004);
    checks++; if (mrs_gap_err !== 1'b0) $display("FAIL gap_8_err got %b exp 0", mrs_gap_err); else passed++;
    idle(22);
    zqcl_rdy = 1'b1; tick(); zqcl_rdy = 1'b0;
    checks++; if (zq_gap_err !== 1'b1) $display("FAIL gap_zq23_err got %b exp 1", zq_gap_err); else passed++;
  endtask

  task automatic test_saturation();
    issue_mrs(3'b000, 18'h00005);
    idle(70);
    issue_mrs(3'b000, 18'h00006);
    checks++; if (mrs_gap_err !== 1'b0) $display("FAIL sat_mrs_err got %b exp 0", mrs_gap_err); else passed++;
  endtask

  task automatic test_conflict();
    do_reset();
    mode_reg = {1'b0, 3'b010, 18'h00018};
    mrs_rdy = 1'b1; zqcl_rdy = 1'b1; tick(); mrs_rdy = 1'b0; zqcl_rdy = 1'b0;
    checks++; if ({pins, BA, A} !== {P_MRS, 2'b10, 18'h00018}) $display("FAIL conflict_bus got %h exp %h", {pins, BA, A}, {P_MRS, 2'b10, 18'h00018}); else passed++;
    checks++; if (errs !== 4'b0010) $display("FAIL conflict_errs got %b exp 0010", errs); else passed++;
    checks++; if (mr_valid !== 7'h04) $display("FAIL conflict_mr_valid got %h exp 04", mr_valid); else passed++;
    des_rdy = 1'b1; tick();
    checks++; if ({pins, errs} !== {P_DES, 4'b0}) $display("FAIL des_alone got %b exp %b", {pins, errs}, {P_DES, 4'b0}); else passed++;
    idle(7);
    issue_mrs(3'b011, 18'h00007);
    des_rdy = 1'b0;
    checks++; if ({pins, errs} !== {P_MRS, 4'b0}) $display("FAIL des_with_mrs got %b exp %b", {pins, errs}, {P_MRS, 4'b0}); else passed++;
    // select 7 goes to the pins but touches no shadow
    idle(7);
    issue_mrs(3'b111, 18'h3FFFF);
    checks++; if ({pins, BG, BA, A} !== {P_MRS, 2'b01, 2'b11, 18'h3FFFF}) $display("FAIL rcw_bus got %h", {pins, BG, BA, A}); else passed++;
    checks++; if ({mr_valid, cwl_code} !== {7'h0C, 3'b011}) $display("FAIL rcw_shadow got %h exp %h", {mr_valid, cwl_code}, {7'h0C, 3'b011}); else passed++;
  endtask

  task automatic test_cfg_err();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i != 0) idle(7);
      issue_mrs(3'(i), 18'(i + 1));
    end
    checks++; if (mr_valid !== 7'h3F) $display("FAIL cfg_mr_valid got %h exp 3f", mr_valid); else passed++;
    ini_done = 1'b1; tick();
    checks++; if ({cfg_ready, cfg_err} !== 2'b01) $display("FAIL cfg_err1 got %b exp 01", {cfg_ready, cfg_err}); else passed++;
    tick(); ini_done = 1'b0;
    checks++; if ({cfg_ready, cfg_err} !== 2'b01) $display("FAIL cfg_err2 got %b exp 01", {cfg_ready, cfg_err}); else passed++;
    tick();
    checks++; if ({cfg_ready, cfg_err} !== 2'b00) $display("FAIL cfg_err_clear got %b exp 00", {cfg_ready, cfg_err}); else passed++;
    idle(6);
    issue_mrs(3'b110, 18'h00C00);
    checks++; if ({mr_valid, tccdl_code, mrs_gap_err} !== {7'h7F, 3'b011, 1'b0})
      $display("FAIL cfg_mr6 got %b exp %b", {mr_valid, tccdl_code, mrs_gap_err}, {7'h7F, 3'b011, 1'b0}); else passed++;
    ini_done = 1'b1; tick(); ini_done = 1'b0;
    checks++; if ({cfg_ready, cfg_err} !== 2'b10) $display("FAIL cfg_ready got %b exp 10", {cfg_ready, cfg_err}); else passed++;
  endtask

  task automatic test_reset_ready();
    mode_reg = {1'b0, 3'b000, 18'h00054};
    reset = 1'b1; mrs_rdy = 1'b1; tick(); reset = 1'b0; mrs_rdy = 1'b0;
    checks++; if ({pins, BG, BA, A} !== {P_DES, 22'h0}) $display("FAIL rst_ready_bus got %h", {pins, BG, BA, A}); else passed++;
    checks++; if ({mr_valid, cfg_ready, errs, tccdl_code} !== 15'h0)
      $display("FAIL rst_ready_state got %h exp 0", {mr_valid, cfg_ready, errs, tccdl_code}); else passed++;
    issue_mrs(3'b000, 18'h00010);
    checks++; if ({pins, mrs_gap_err} !== {P_MRS, 1'b0}) $display("FAIL rst_first_mrs got %b exp %b", {pins, mrs_gap_err}, {P_MRS, 1'b0}); else passed++;
  endtask

  initial begin
    reset = 1'b1; mrs_rdy = 1'b0; zqcl_rdy = 1'b0; des_rdy = 1'b0; ini_done = 1'b0;
    mode_reg = '0;
    test_reset();
    test_first_mrs();
    test_init_sequence();
    test_gap_errors();
    test_saturation();
    test_conflict();
    test_cfg_err();
    test_reset_ready();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
